seq_priority_encoder_16x4: RTL and testbench

- Sequential 16-to-4 priority encoder; the inverse of the team's 4x16 one-hot decoder.
- Captures a 16-bit request vector and then emits the 4-bit code of every set bit, one per handshake, highest priority first.
- Code mapping matches the decoder: code c corresponds to vector bit d[15-c]. So code 0 is bit 15, and code 15 is bit 0.
- Sits between request sources (interrupt lines, decoded selects) and a consumer that services one index at a time.

---
 rtl/seq_priority_encoder_16x4.sv | 138 +++++++++++++
 tb/tb_seq_priority_encoder_16x4.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/seq_priority_encoder_16x4.sv
// Sequential 16-to-4 priority encoder: captures a multi-hot request vector and
// emits the code of every set bit, highest bit (lowest code) first, one per handshake.
module seq_priority_encoder_16x4 #(
  parameter int CODE_W = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_vld,
  input  logic [15:0] req_vec,
  output logic        req_rdy,
  output logic        code_vld,
  output logic [3:0]  code,
  output logic        code_last,
  input  logic        code_rdy,
  output logic [4:0]  pend_cnt,
  output logic        zero_err
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  state_t      state_r, state_s;
  logic [15:0] pending_r, pending_s;
  logic        code_vld_r, code_vld_s;
  logic [3:0]  code_r, code_s;
  logic        code_last_r, code_last_s;
  logic [4:0]  pend_cnt_r, pend_cnt_s;
  logic        zero_err_r, zero_err_s;
  logic [15:0] cleared_s;

  // Code of the highest set bit; code c maps to vector bit 15-c.
  function automatic logic [3:0] top_code(input logic [15:0] v);
    logic [3:0] res;
    res = 4'd0;
    for (int c = 15; c >= 0; c--) begin
      if (v[15-c]) begin
        res = c[3:0];
      end
    end
    return res;
  endfunction

  function automatic logic [4:0] popcount(input logic [15:0] v);
    logic [4:0] cnt;
    cnt = 5'd0;
    for (int i = 0; i < 16; i++) begin
      cnt = cnt + {4'd0, v[i]};
    end
    return cnt;
  endfunction

  assign req_rdy   = (state_r == IDLE) & ~rst;
  assign code_vld  = code_vld_r;
  assign code      = code_r;
  assign code_last = code_last_r;
  assign pend_cnt  = pend_cnt_r;
  assign zero_err  = zero_err_r;

  // Pending vector with the currently presented bit removed.
  assign cleared_s = pending_r & ~(16'h8000 >> code_r);

  // Next-state and next-output computation.
  always_comb begin
    state_s     = state_r;
    pending_s   = pending_r;
    code_vld_s  = code_vld_r;
    code_s      = code_r;
    code_last_s = code_last_r;
    pend_cnt_s  = pend_cnt_r;
    zero_err_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (req_vld) begin
          if (req_vec != 16'd0) begin
            pending_s   = req_vec;
            state_s     = EMIT;
            code_vld_s  = 1'b1;
            code_s      = top_code(req_vec);
            pend_cnt_s  = popcount(req_vec);
            code_last_s = (popcount(req_vec) == 5'd1);
          end else begin
            zero_err_s = 1'b1;
          end
        end else begin
          zero_err_s = 1'b0;
        end
      end
      EMIT: begin
        if (code_rdy) begin
          pending_s  = cleared_s;
          pend_cnt_s = pend_cnt_r - 5'd1;
          if (cleared_s != 16'd0) begin
            code_s      = top_code(cleared_s);
            code_last_s = (pend_cnt_r == 5'd2);
          end else begin
            code_vld_s  = 1'b0;
            code_last_s = 1'b0;
            state_s     = IDLE;
          end
        end else begin
          pending_s = pending_r;
        end
      end
      default: begin
        state_s     = IDLE;
        pending_s   = 16'd0;
        code_vld_s  = 1'b0;
        code_s      = 4'd0;
        code_last_s = 1'b0;
        pend_cnt_s  = 5'd0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      pending_r   <= 16'd0;
      code_vld_r  <= 1'b0;
      code_r      <= 4'd0;
      code_last_r <= 1'b0;
      pend_cnt_r  <= 5'd0;
      zero_err_r  <= 1'b0;
    end else begin
      state_r     <= state_s;
      pending_r   <= pending_s;
      code_vld_r  <= code_vld_s;
      code_r      <= code_s;
      code_last_r <= code_last_s;
      pend_cnt_r  <= pend_cnt_s;
      zero_err_r  <= zero_err_s;
    end
  end

endmodule

// File: tb/tb_seq_priority_encoder_16x4.sv
// Self-checking bench for seq_priority_encoder_16x4 with a queue-based reference model.
module tb_seq_priority_encoder_16x4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_vld = 1'b0;
  logic [15:0] req_vec = 16'd0;
  logic        req_rdy;
  logic        code_vld;
  logic [3:0]  code;
  logic        code_last;
  logic        code_rdy = 1'b0;
  logic [4:0]  pend_cnt;
  logic        zero_err;

  int checks = 0;
  int failures = 0;

  seq_priority_encoder_16x4 dut (
    .clk(clk), .rst(rst), .req_vld(req_vld), .req_vec(req_vec), .req_rdy(req_rdy),
    .code_vld(code_vld), .code(code), .code_last(code_last), .code_rdy(code_rdy),
    .pend_cnt(pend_cnt), .zero_err(zero_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sends one vector, drains it with the given stall pattern and checks every code.
  task automatic run_vector(input logic [15:0] vec, input int stall_first,
                            input bit rnd_stall, input bit junk);
    int q[$];
    int n;
    int nst;
    int waited;
    waited = 0;
    while (!req_rdy && waited < 20) begin
      tick();
      waited++;
    end
    checks++;
    if (!req_rdy) begin
      failures++;
      $display("FAIL rdy_timeout vec=%h req_rdy=%0b required 1", vec, req_rdy);
      return;
    end
    for (int b = 15; b >= 0; b--) begin
      if (vec[b]) q.push_back(15 - b);
    end
    req_vld = 1'b1;
    req_vec = vec;
    tick();
    req_vld = 1'b0;
    if (q.size() == 0) begin
      checks++;
      if (zero_err !== 1'b1 || code_vld !== 1'b0 || req_rdy !== 1'b1) begin
        failures++;
        $display("FAIL zero_vec zero_err=%0b code_vld=%0b req_rdy=%0b required 1/0/1",
                 zero_err, code_vld, req_rdy);
      end
      tick();
      checks++;
      if (zero_err !== 1'b0) begin
        failures++;
        $display("FAIL zero_pulse zero_err=%0b required 0", zero_err);
      end
      return;
    end
    n = q.size();
    for (int i = 0; i < n; i++) begin
      nst = (i == 0) ? stall_first : (rnd_stall ? int'($urandom_range(0, 2)) : 0);
      for (int s = 0; s <= nst; s++) begin
        code_rdy = (s == nst);
        if (junk && s != nst) begin
          req_vld = 1'b1;
          req_vec = 16'($urandom());
        end else begin
          req_vld = 1'b0;
        end
        checks++;
        if (code_vld !== 1'b1 || code !== 4'(q[i]) || pend_cnt !== 5'(n - i) ||
            code_last !== (n - i == 1) || zero_err !== 1'b0 || req_rdy !== 1'b0) begin
          failures++;
          $display("FAIL emit vec=%h idx=%0d got vld=%0b code=%0d cnt=%0d last=%0b zerr=%0b rdy=%0b required 1/%0d/%0d/%0b/0/0",
                   vec, i, code_vld, code, pend_cnt, code_last, zero_err, req_rdy,
                   q[i], n - i, (n - i == 1));
        end
        tick();
      end
    end
    code_rdy = 1'b0;
    req_vld  = 1'b0;
    checks++;
    if (code_vld !== 1'b0 || pend_cnt !== 5'd0 || code_last !== 1'b0 || req_rdy !== 1'b1) begin
      failures++;
      $display("FAIL drained vec=%h vld=%0b cnt=%0d last=%0b rdy=%0b required 0/0/0/1",
               vec, code_vld, pend_cnt, code_last, req_rdy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (req_rdy !== 1'b0 || code_vld !== 1'b0 || code !== 4'd0 || code_last !== 1'b0 ||
        pend_cnt !== 5'd0 || zero_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_state rdy=%0b vld=%0b code=%0d last=%0b cnt=%0d zerr=%0b required all 0",
               req_rdy, code_vld, code, code_last, pend_cnt, zero_err);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (req_rdy !== 1'b1) begin
      failures++;
      $display("FAIL reset_release req_rdy=%0b required 1", req_rdy);
    end
  endtask

  task automatic test_single();
    run_vector(16'h8000, 0, 1'b0, 1'b0);
    run_vector(16'h0001, 0, 1'b0, 1'b0);
    run_vector(16'h0400, 0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_vector(16'h8421, 0, 1'b0, 1'b0);
  endtask

  task automatic test_stall();
    run_vector(16'h8421, 3, 1'b0, 1'b1);
  endtask

  task automatic test_zero();
    run_vector(16'h0000, 0, 1'b0, 1'b0);
  endtask

  task automatic test_full_and_reset();
    run_vector(16'hFFFF, 0, 1'b0, 1'b0);
    tick();
    req_vld  = 1'b1;
    req_vec  = 16'hFFFF;
    tick();
    req_vld  = 1'b0;
    code_rdy = 1'b1;
    repeat (6) tick();
    checks++;
    if (code !== 4'd6 || code_vld !== 1'b1) begin
      failures++;
      $display("FAIL repeat_run code=%0d vld=%0b required 6/1", code, code_vld);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (code_vld !== 1'b0 || pend_cnt !== 5'd0 || req_rdy !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset vld=%0b cnt=%0d rdy=%0b required 0/0/0", code_vld, pend_cnt, req_rdy);
    end
    code_rdy = 1'b0;
    tick();
    rst = 1'b0;
    run_vector(16'h0100, 0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int t = 0; t < 25; t++) begin
      run_vector(16'($urandom()) & ((t % 5 == 0) ? 16'h0F0F : 16'hFFFF),
                 int'($urandom_range(0, 2)), 1'b1, 1'b1);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_zero();
    test_full_and_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
